// File: rtl/light_pkg.sv
// Shared constants for the light decoder: traffic light codes, checker
// state encoding and the seven-segment die table.
package light_pkg;

  // Traffic light codes as driven by the upstream generator
  localparam logic [2:0] TL_RED     = 3'b100;
  localparam logic [2:0] TL_RED_AMB = 3'b110;
  localparam logic [2:0] TL_GREEN   = 3'b001;
  localparam logic [2:0] TL_AMBER   = 3'b010;

  // Traffic checker state encoding, visible on tl_state
  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_RED     = 3'd2;
  localparam logic [2:0] ST_RED_AMB = 3'd3;
  localparam logic [2:0] ST_GREEN   = 3'd4;
  localparam logic [2:0] ST_AMBER   = 3'd5;

  // Seven-segment patterns {g,f,e,d,c,b,a} indexed by die code; 0 and 7 are blank
  localparam logic [7:0][6:0] SEG_TABLE = {
    7'b0000000,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0000000   // 0
  };

  // Lit state matching a traffic code; illegal codes map to SYNC
  function automatic logic [2:0] tl_state_of(input logic [2:0] c);
    case (c)
      TL_RED:     return ST_RED;
      TL_RED_AMB: return ST_RED_AMB;
      TL_GREEN:   return ST_GREEN;
      TL_AMBER:   return ST_AMBER;
      default:    return ST_SYNC;
    endcase
  endfunction

  // Next lit state in the RED->RED_AMB->GREEN->AMBER->RED cycle
  function automatic logic [2:0] tl_succ(input logic [2:0] s);
    case (s)
      ST_RED:     return ST_RED_AMB;
      ST_RED_AMB: return ST_GREEN;
      ST_GREEN:   return ST_AMBER;
      ST_AMBER:   return ST_RED;
      default:    return s;
    endcase
  endfunction

endpackage

// File: rtl/seg7_dice.sv
// Combinational die-code to seven-segment lookup.
module seg7_dice
  import light_pkg::*;
(
  input  logic [2:0] code,
  output logic [6:0] seg,
  output logic       valid
);

  // Table lookup; only codes 1..6 are real die faces
  always_comb begin
    seg   = SEG_TABLE[code];
    valid = (code != 3'd0) && (code != 3'd7);
  end

endmodule

// File: rtl/light_decoder.sv
// Dual-mode decoder: traffic-light sequence checker or die display with
// a saturating count of value changes. All outputs are registered.
module light_decoder
  import light_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic [2:0] code,
  input  logic       err_clr,
  output logic [6:0] seg,
  output logic       dice_valid,
  output logic [2:0] tl_state,
  output logic       tl_err,
  output logic       dice_err,
  output logic [7:0] roll_cnt
);

  logic [6:0] die_seg;
  logic       die_ok;
  logic [2:0] code_state;
  logic [2:0] tl_next;
  logic       tl_bad;
  logic       dice_bad;
  logic       roll_inc;
  // Last legal die value; 0 means "none" since 0 is never a legal face
  logic [2:0] last_val;

  seg7_dice u_seg7 (
    .code  (code),
    .seg   (die_seg),
    .valid (die_ok)
  );

  // Traffic checker next state and sequence-error detection
  always_comb begin
    tl_next    = ST_OFF;
    tl_bad     = 1'b0;
    code_state = tl_state_of(code);
    if (sel) begin
      case (tl_state)
        ST_OFF: tl_next = ST_SYNC;
        ST_SYNC: begin
          tl_next = code_state;
          tl_bad  = (code_state == ST_SYNC);
        end
        ST_RED, ST_RED_AMB, ST_GREEN, ST_AMBER: begin
          if (code_state == tl_state) begin
            tl_next = tl_state;
          end else if (code_state == tl_succ(tl_state)) begin
            tl_next = code_state;
          end else begin
            tl_next = ST_SYNC;
            tl_bad  = 1'b1;
          end
        end
        default: tl_next = ST_SYNC;
      endcase
    end
  end

  // Die-mode error and change detection
  always_comb begin
    dice_bad = !sel && !die_ok;
    roll_inc = !sel && die_ok && (code != last_val);
  end

  // Output and state registers; a same-edge error beats err_clr on the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'd0;
      dice_valid <= 1'b0;
      tl_state   <= ST_OFF;
      tl_err     <= 1'b0;
      dice_err   <= 1'b0;
      roll_cnt   <= 8'd0;
      last_val   <= 3'd0;
    end else begin
      tl_state   <= tl_next;
      seg        <= (!sel && die_ok) ? die_seg : 7'd0;
      dice_valid <= !sel && die_ok;
      tl_err     <= tl_bad   | (tl_err   & ~err_clr);
      dice_err   <= dice_bad | (dice_err & ~err_clr);
      if (err_clr) begin
        roll_cnt <= 8'd0;
        last_val <= 3'd0;
      end else if (roll_inc) begin
        last_val <= code;
        if (roll_cnt != 8'hFF) roll_cnt <= roll_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_light_decoder.sv
// Directed bench for light_decoder with hand-computed expectations.
module tb_light_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] code = 3'd0;
  logic       err_clr = 1'b0;
  logic [6:0] seg;
  logic       dice_valid;
  logic [2:0] tl_state;
  logic       tl_err;
  logic       dice_err;
  logic [7:0] roll_cnt;

  int checks = 0;
  int errors = 0;

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  light_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .code       (code),
    .err_clr    (err_clr),
    .seg        (seg),
    .dice_valid (dice_valid),
    .tl_state   (tl_state),
    .tl_err     (tl_err),
    .dice_err   (dice_err),
    .roll_cnt   (roll_cnt)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Compare every output against one expected vector
  task automatic check_all(input string tag, input logic [6:0] e_seg,
                           input logic e_valid, input logic [2:0] e_state,
                           input logic e_tl, input logic e_de, input logic [7:0] e_cnt);
    check_output({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check_output({tag, ".dice_valid"}, 32'(dice_valid), 32'(e_valid));
    check_output({tag, ".tl_state"}, 32'(tl_state), 32'(e_state));
    check_output({tag, ".tl_err"}, 32'(tl_err), 32'(e_tl));
    check_output({tag, ".dice_err"}, 32'(dice_err), 32'(e_de));
    check_output({tag, ".roll_cnt"}, 32'(roll_cnt), 32'(e_cnt));
  endtask

  // Drive inputs on the falling edge, sample just after the next rising edge
  task automatic apply_stimulus(input logic s, input logic [2:0] c, input logic clr);
    @(negedge clk);
    sel = s;
    code = c;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] tl_codes [7] = '{3'b100, 3'b100, 3'b110, 3'b001, 3'b001, 3'b010, 3'b100};
  logic [2:0] tl_exp   [7] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd2};
  logic [2:0] dice_codes [5] = '{3'd4, 3'd4, 3'd2, 3'd7, 3'd2};
  logic [6:0] dice_seg   [5] = '{7'b1100110, 7'b1100110, 7'b1011011, 7'b0000000, 7'b1011011};
  logic       dice_vld   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] dice_cnt   [5] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
  logic       dice_de    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    $display("[TB] light_decoder directed test");

    // Reset held across clock edges
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold", 7'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);

    // Release reset and enter traffic mode: OFF -> SYNC
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;
    code = 3'b100;
    @(posedge clk);
    #1;
    check_all("tl_sync", 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0);

    // Legal traffic sequence
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, tl_codes[i], 1'b0);
      check_output($sformatf("tl_legal%0d.state", i), 32'(tl_state), 32'(tl_exp[i]));
      check_output($sformatf("tl_legal%0d.err", i), 32'(tl_err), 32'd0);
    end

    // Illegal jump RED -> GREEN, flag persists
    apply_stimulus(1'b1, 3'b001, 1'b0);
    check_all("tl_jump", 7'd0, 1'b0, 3'd1, 1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b1, 3'b001, 1'b0);
    check_all("tl_jump_resync", 7'd0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b1, 3'b010, 1'b0);
    check_all("tl_jump_persist", 7'd0, 1'b0, 3'd5, 1'b1, 1'b0, 8'd0);

    // Switch to dice mode keeps tl_err
    apply_stimulus(1'b0, 3'd3, 1'b0);
    check_all("to_dice", 7'b1001111, 1'b1, 3'd0, 1'b1, 1'b0, 8'd1);

    // err_clr with a simultaneous die error: dice_err set, others clear
    apply_stimulus(1'b0, 3'd7, 1'b1);
    check_all("clr_vs_err", 7'd0, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0);

    // Plain clear from traffic mode
    apply_stimulus(1'b1, 3'b100, 1'b1);
    check_all("clr_tl", 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0);

    // Dice sequence 4,4,2,7,2
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, dice_codes[i], 1'b0);
      check_all($sformatf("dice%0d", i), dice_seg[i], dice_vld[i], 3'd0, 1'b0,
                dice_de[i], dice_cnt[i]);
    end

    // Saturation of roll_cnt
    apply_stimulus(1'b1, 3'b100, 1'b1);
    check_all("sat_clr", 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b0, (i % 2 == 0) ? 3'd1 : 3'd2, 1'b0);
      if (i == 253) check_output("sat_254", 32'(roll_cnt), 32'd254);
      if (i == 254) check_output("sat_255", 32'(roll_cnt), 32'd255);
    end
    check_all("sat_end", 7'b1011011, 1'b1, 3'd0, 1'b0, 1'b0, 8'd255);
    apply_stimulus(1'b1, 3'b100, 1'b1);
    check_all("sat_cleared", 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0);

    // Mode switch: dice 4, then traffic GREEN
    apply_stimulus(1'b0, 3'd4, 1'b0);
    check_all("sw_dice", 7'b1100110, 1'b1, 3'd0, 1'b0, 1'b0, 8'd1);
    apply_stimulus(1'b1, 3'b001, 1'b0);
    check_all("sw_sync", 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd1);
    apply_stimulus(1'b1, 3'b001, 1'b0);
    check_all("sw_green", 7'd0, 1'b0, 3'd4, 1'b0, 1'b0, 8'd1);

    // Asynchronous reset mid-clock
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 7'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    check_all("async_reset_hold", 7'd0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);

    // Restart traffic checking after reset release
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;
    code = 3'b001;
    @(posedge clk);
    #1;
    check_all("restart_sync", 7'd0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0);
    apply_stimulus(1'b1, 3'b001, 1'b0);
    check_all("restart_green", 7'd0, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/light_decoder.md
LIGHT_DECODER -- requirements
Module: light_decoder

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single rising-edge clock for all state.
REQ-002 The block SHALL have the port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-003 The block SHALL have the port sel, input, 1 bit: 1 selects traffic-light mode, 0 selects dice mode.
REQ-004 The block SHALL have the port code, input, 3 bits, the value driven by the upstream dice/traffic generator, sampled every clk.
REQ-005 The block SHALL have the port err_clr, input, 1 bit, which clears the sticky errors and roll_cnt.
REQ-006 The block SHALL have the port seg, output, 7 bits, an active-high seven-segment pattern {g,f,e,d,c,b,a}.
REQ-007 The block SHALL have the port dice_valid, output, 1 bit, high when seg shows a legal die value.
REQ-008 The block SHALL have the port tl_state, output, 3 bits, the current traffic checker state.
REQ-009 The block SHALL have the port tl_err, output, 1 bit, a sticky flag for an illegal traffic sequence or code.
REQ-010 The block SHALL have the port dice_err, output, 1 bit, a sticky flag for an illegal die code (0 or 7).
REQ-011 The block SHALL have the port roll_cnt, output, 8 bits, the count of die value changes, saturating.

Function
REQ-012 The block SHALL register all outputs, so that an output reflects the code/sel sampled at edge N from edge N onward (1-cycle latency).
REQ-013 In traffic mode the legal codes SHALL be RED=100, RED_AMB=110, GREEN=001, AMBER=010, with the cycle RED->RED_AMB->GREEN->AMBER->RED.
REQ-014 The tl_state encoding SHALL be OFF=0, SYNC=1, RED=2, RED_AMB=3, GREEN=4, AMBER=5.
REQ-015 The checker SHALL be in OFF whenever sel=0, and SHALL move OFF->SYNC on the first cycle with sel=1.
REQ-016 In SYNC, any legal traffic code SHALL move the checker to the matching state; an illegal code SHALL set tl_err and stay in SYNC.
REQ-017 In a lit state, a code equal to the current state SHALL hold the state, the successor code SHALL advance the state, and any other code SHALL set tl_err and go to SYNC.
REQ-018 In dice mode (sel=0), codes 1..6 SHALL drive seg as 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, with dice_valid=1.
REQ-019 In dice mode, codes 0 and 7 SHALL drive seg=0000000 and dice_valid=0, set dice_err, and leave the last legal value unchanged.
REQ-020 roll_cnt SHALL increment when a legal die code differs from the last legal die code; the first legal code after reset or err_clr SHALL count; roll_cnt SHALL saturate at 255.
REQ-021 In traffic mode, seg SHALL be 0000000, dice_valid=0, and roll_cnt SHALL hold.
REQ-022 A sel change SHALL take effect on the same edge it is sampled; switching to dice mode SHALL NOT clear tl_err.
REQ-023 On err_clr=1, tl_err, dice_err, roll_cnt and the last-legal-value memory SHALL clear at that edge; an error detected on the same edge SHALL win, so the flag is set.
REQ-024 The block SHALL NOT have any combinational path from an input to an output.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force seg=0, dice_valid=0, tl_state=OFF, tl_err=0, dice_err=0, roll_cnt=0, and last legal value = none.
REQ-026 Deasserting rst_n mid-sequence SHALL restart traffic checking from OFF/SYNC with no error raised.

Structure
REQ-027 A shared package light_pkg SHALL hold the traffic code constants, the tl_state encoding and the seven-segment table.
REQ-028 The seven-segment lookup SHALL be a separate combinational sub-module, seg7_dice, instantiated once.

Verification
REQ-029 Reset: with rst_n=0 asserted asynchronously mid-clock, all outputs SHALL be 0 before the next edge.
REQ-030 Legal traffic: with sel=1 and code 100,100,110,001,001,010,100, tl_state SHALL go 1->2->2->3->4->4->5->2 and tl_err SHALL stay 0.
REQ-031 Illegal jump: with sel=1, RED then GREEN, tl_err SHALL be 1 one edge later, tl_state=SYNC, and the flag SHALL persist until err_clr.
REQ-032 Dice: with sel=0 and code 4,4,2,7,2, seg SHALL be 1100110, 1100110, 1011011, 0000000, 1011011; roll_cnt SHALL be 2; dice_err=1.
REQ-033 Saturation: 300 alternating codes 1/2 SHALL leave roll_cnt=255; err_clr then SHALL give roll_cnt=0.
REQ-034 Mode switch: dice 4 then sel=1 with code 001 SHALL give seg=0, tl_state=SYNC then GREEN, and roll_cnt held.
